// File: rtl/cmp_seq.sv
// Sequential wide-operand comparator: walks two COUNT-word operands one
// W-bit word per cycle from the most significant word down, reusing a single
// narrow comparator and stopping on the first differing word.
module cmp_seq #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned COUNT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [(2**ORDER)*COUNT-1:0]     a,
    input  logic [(2**ORDER)*COUNT-1:0]     b,
    input  logic                            sgn,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            lt,
    output logic                            eq,
    output logic                            gt,
    output logic                            busy
);

    localparam int unsigned W  = 2**ORDER;
    localparam int unsigned D  = W * COUNT;
    localparam int unsigned IW = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(COUNT - 1);
    localparam logic [W-1:0]  MSB_BIT = W'(1) << (W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  ra_q, ra_d;
    logic [D-1:0]  rb_q, rb_d;
    logic          sign_q, sign_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;

    logic [W-1:0]  wa_c, wb_c;
    logic [W-1:0]  flip_c;
    logic          word_lt_c, word_eq_c, word_gt_c;

    // Select the current word; bias the top word into unsigned order for signed compares
    always_comb begin
        flip_c = (sign_q && (idx_q == IDX_TOP)) ? MSB_BIT : '0;
        wa_c   = W'(ra_q >> (32'(idx_q) * W)) ^ flip_c;
        wb_c   = W'(rb_q >> (32'(idx_q) * W)) ^ flip_c;
    end

    cmp #(
        .ORDER (ORDER)
    ) u_cmp (
        .a    (wa_c),
        .b    (wb_c),
        .lt_c (word_lt_c),
        .eq_c (word_eq_c),
        .gt_c (word_gt_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sign_d  = sign_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    sign_d  = sgn;
                    idx_d   = IDX_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!word_eq_c) begin
                    lt_d    = word_lt_c;
                    eq_d    = 1'b0;
                    gt_d    = word_gt_c;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    // Operand copies carry no reset; they are always loaded before use
    always_ff @(posedge clk) begin
        ra_q <= ra_d;
        rb_q <= rb_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;

endmodule

// Narrow unsigned word comparator shared across all word positions
module cmp #(
    parameter int unsigned ORDER = 3
) (
    input  logic [2**ORDER-1:0] a,
    input  logic [2**ORDER-1:0] b,
    output logic                lt_c,
    output logic                eq_c,
    output logic                gt_c
);

    // Plain magnitude compare of one word
    always_comb begin
        lt_c = (a < b);
        eq_c = (a == b);
        gt_c = (a > b);
    end

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq: a 4-word and a 1-word instance, directed
// cases plus random requests checked against a whole-operand reference model.
module tb_cmp_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid0, in_ready0, sgn0, out_valid0, out_ready0;
    logic        lt0, eq0, gt0, busy0;
    logic [31:0] a0, b0;

    logic        in_valid1, in_ready1, sgn1, out_valid1, out_ready1;
    logic        lt1, eq1, gt1, busy1;
    logic [7:0]  a1, b1;

    int n_checks;
    int n_errors;

    cmp_seq #(.ORDER(3), .COUNT(4)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .sgn       (sgn0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .lt        (lt0),
        .eq        (eq0),
        .gt        (gt0),
        .busy      (busy0)
    );

    cmp_seq #(.ORDER(3), .COUNT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .sgn       (sgn1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .lt        (lt1),
        .eq        (eq1),
        .gt        (gt1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // {in_ready, busy, out_valid, lt, eq, gt}
    function automatic logic [5:0] outs(input int which);
        if (which == 0) return {in_ready0, busy0, out_valid0, lt0, eq0, gt0};
        return {in_ready1, busy1, out_valid1, lt1, eq1, gt1};
    endfunction

    task automatic drive(input int which, input logic iv, input logic [31:0] x,
                         input logic [31:0] y, input logic s, input logic ordy);
        if (which == 0) begin
            in_valid0 = iv; a0 = x; b0 = y; sgn0 = s; out_ready0 = ordy;
        end else begin
            in_valid1 = iv; a1 = 8'(x); b1 = 8'(y); sgn1 = s; out_ready1 = ordy;
        end
    endtask

    // Whole-operand reference: signed/unsigned ordering and number of words examined
    function automatic void model(input logic [31:0] x_in, input logic [31:0] y_in,
                                  input logic s, input int cnt, output int k,
                                  output logic elt, output logic eeq, output logic egt);
        int          d;
        int          hb;
        logic [31:0] m, x, y, diff;
        longint      sx, sy;
        d  = cnt * 8;
        m  = (d >= 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 32'd1);
        x  = x_in & m;
        y  = y_in & m;
        sx = longint'({32'd0, x});
        sy = longint'({32'd0, y});
        if (s && x[d-1]) sx = sx - (longint'(1) << d);
        if (s && y[d-1]) sy = sy - (longint'(1) << d);
        elt  = (sx < sy);
        eeq  = (sx == sy);
        egt  = (sx > sy);
        diff = x ^ y;
        hb   = -1;
        for (int i = 0; i < 32; i++) if (diff[i]) hb = i;
        k = (hb < 0) ? cnt : cnt - hb / 8;
    endfunction

    // One full request: accept, wait for result, optional backpressure, drain
    task automatic req(input int which, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input int stall);
        int         cnt, k, lat;
        logic       elt, eeq, egt;
        logic [5:0] o, held;
        cnt = (which == 0) ? 4 : 1;
        model(x, y, s, cnt, k, elt, eeq, egt);
        o = outs(which);
        chk("idle_in_ready", o[5], 1);
        drive(which, 1'b1, x, y, s, (stall == 0));
        @(posedge clk); #1;
        drive(which, 1'b0, $urandom, $urandom, 1'($urandom), (stall == 0));
        o = outs(which);
        chk("accept_busy", o[4], 1);
        lat = 0;
        while (!outs(which)[3] && lat < 2 * cnt + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        o = outs(which);
        chk("latency", lat, k);
        chk("out_valid", o[3], 1);
        chk("in_ready_done", o[5], 0);
        chk("lt", o[2], elt);
        chk("eq", o[1], eeq);
        chk("gt", o[0], egt);
        held = o;
        for (int i = 0; i < stall; i++) begin
            drive(which, 1'b1, $urandom, $urandom, 1'($urandom), 1'b0);
            @(posedge clk); #1;
            o = outs(which);
            chk("stall_hold", o, held);
        end
        if (which == 0) out_ready0 = 1'b1; else out_ready1 = 1'b1;
        @(posedge clk); #1;
        o = outs(which);
        chk("drain_out_valid", o[3], 0);
        chk("drain_in_ready", o[5], 1);
        if (which == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    endtask

    initial begin
        logic [31:0] x, y;
        logic [5:0]  o;
        int          bi;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("reset_dut0", outs(0), 6'b100000);
        chk("reset_dut1", outs(1), 6'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        req(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        req(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
        req(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
        req(0, 32'h0000_0102, 32'h0000_0103, 1'b0, 0);
        req(0, 32'h0001_FF00, 32'h0002_0000, 1'b0, 0);
        req(0, 32'h0000_0009, 32'h0000_0003, 1'b0, 5);
        req(1, 32'h0000_00FF, 32'h0000_0001, 1'b1, 0);
        req(1, 32'h0000_0005, 32'h0000_0005, 1'b1, 0);

        // Reset during the second RUN cycle discards the compare
        drive(0, 1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", outs(0), 6'b100000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            o = outs(0);
            chk("reset_no_valid", o[3], 0);
        end
        rst_n = 1'b1;
        req(0, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1, 0);

        // Random requests on the 4-word instance
        for (int t = 0; t < 40; t++) begin
            x = $urandom;
            case ($urandom_range(0, 2))
                0: y = $urandom;
                1: y = x;
                default: begin
                    y  = x;
                    bi = $urandom_range(0, 31);
                    y[bi] = ~y[bi];
                end
            endcase
            req(0, x, y, 1'($urandom), $urandom_range(0, 3));
        end

        // Random requests on the 1-word instance
        for (int t = 0; t < 20; t++) begin
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            req(1, x, y, 1'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Sequential wide-operand comparator. It compares two COUNT-word operands one W-bit word per cycle, starting at the most significant word.
- It reuses a single narrow cmp instance (ORDER parameter) instead of a full-width comparator tree.
- It stops early on the first differing word.
- It sits between a requester (ready/valid in) and a consumer (ready/valid out) in the ALU control path.

Parameters:
ORDER, 3, word width W = 2**ORDER bits; passed to the internal cmp instance.
COUNT, 4, words per operand (COUNT >= 1); operand width D = W*COUNT.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  request present.
in_ready  out  1  block can accept a request; high exactly when state is IDLE.
a  in  D  operand A, sampled on accept.
b  in  D  operand B, sampled on accept.
sgn  in  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
out_valid  out  1  result valid; high exactly when state is DONE.
out_ready  in  1  consumer takes result.
lt  out  1  A < B.
eq  out  1  A == B.
gt  out  1  A > B.
busy  out  1  high in RUN or DONE (= !in_ready).

Behaviour:
- States: IDLE, RUN, DONE. Registers:
  - operand copies ra, rb (D bits);
  - sign flag;
  - word index idx, width max(1, clog2(COUNT));
  - result flags lt, eq, gt.
- Reset (rst_n low, asynchronous, any state including mid-RUN):
  - state becomes IDLE; idx, lt, eq and gt become 0; out_valid = 0; busy = 0; in_ready = 1.
  - Any in-flight compare is discarded with no output.
  - ra and rb need not be cleared.
- IDLE: on an edge where in_valid && in_ready:
  - load ra = a, rb = b, sign = sgn, idx = COUNT-1;
  - go to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - Word idx of ra and rb (bits idx*W+W-1 .. idx*W) drives the cmp instance combinationally.
  - Signed handling: when sign = 1 and idx = COUNT-1, invert the MSB of both words before cmp (bias to unsigned order). All other words compare unsigned.
  - If cmp eq = 0: register lt/gt from cmp, eq = 0, go to DONE.
  - Else if idx = 0: register eq = 1, lt = gt = 0, go to DONE.
  - Else: idx <= idx-1, stay in RUN.
- Latency:
  - out_valid rises k edges after the accept edge, where k = number of words examined (1..COUNT).
  - Equal operands always take COUNT cycles.
  - COUNT = 1 gives fixed 1-cycle latency.
- DONE:
  - lt/eq/gt held stable while out_valid = 1; exactly one of the three is 1.
  - On an edge with out_ready = 1, go to IDLE. Flags may keep their last value but are only meaningful while out_valid = 1.
  - in_ready = 0 throughout DONE. No accept-while-draining; the minimum request spacing is k+2 cycles.
- in_valid while busy:
  - ignored, with no effect on state or operands.
  - The requester must hold in_valid and the request data until in_ready.
- Input changes:
  - a, b and sgn may change freely after the accept edge; the result depends only on the values sampled.
  - out_ready is ignored outside DONE.

Test Plan:
- ORDER=3, COUNT=4, sgn=0, a=0x12345678, b=0x12345678, out_ready=1 -> out_valid 4 edges after accept, eq=1 lt=0 gt=0, back in IDLE next edge.
- sgn=0, a=0x80000000, b=0x7FFFFFFF -> out_valid 1 edge after accept, gt=1. Same operands with sgn=1 -> lt=1, also after 1 edge.
- sgn=0, a=0x00000102, b=0x00000103 -> lt=1 after 4 edges. a=0x0001FF00, b=0x00020000 -> lt=1 after 2 edges.
- Backpressure: result gt, out_ready low 5 cycles with in_valid high throughout -> out_valid and gt held, in_ready=0, new request not taken until one edge after out_ready rises.
- Reset mid-RUN: accept equal operands, drop rst_n during the 2nd RUN cycle -> outputs clear immediately (asynchronously), in_ready=1, no out_valid. A new request after release completes normally.
- COUNT=1, ORDER=3, sgn=1: a=0xFF, b=0x01 -> lt=1 after 1 edge. a=0x05, b=0x05 -> eq=1 after 1 edge.
